// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline controller: stall polarity, arbiter
// state encodings and the stall vector rows.
package pipe_ctrl_pkg;

  // Stall bit polarity as seen by the pipeline registers.
  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // RAM port arbiter states.
  typedef logic [1:0] arb_state_t;
  localparam arb_state_t ARB_IDLE = 2'd0;
  localparam arb_state_t ARB_IF   = 2'd1;
  localparam arb_state_t ARB_MEM  = 2'd2;

  // Stall vector rows, bit0 = pc .. bit5 = wb.
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_NONE = 6'b000000;

  // Byte enables used for instruction fetches (always a full word).
  localparam logic [3:0] FETCH_SEL = 4'b1111;

endpackage

// File: rtl/pipe_ctrl_mem_port_arb.sv
// Single shared RAM port arbiter. MEM wins over IF because it carries the
// older instruction. Exactly one RAM access is outstanding at a time; every
// ram_* output comes straight from a register.
//
// Handshake: ram_req_o rises with all ram_* fields and they stay frozen
// until ram_ack_i is seen high while in IF/MEM access state. The ack cycle
// ends the access; the following cycle is IDLE with a one-cycle done pulse
// and the captured read data. An ack while IDLE (including the grant
// cycle) is not part of any access and is ignored.
module mem_port_arb
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_id_i,
  input  logic              branch_flag_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_done_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic [3:0]        mem_sel_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_done_o,
  output logic              ram_req_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  output logic [3:0]        ram_sel_o,
  input  logic              ram_ack_i,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic [1:0]        state_o
);

  arb_state_t        state_q, state_d;
  logic              ram_req_q, ram_req_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [3:0]        ram_sel_q, ram_sel_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              drop_q, drop_d;

  logic mem_elig;
  logic if_elig;
  logic if_grant;
  logic drop_set;

  // Eligibility, IF grant detection and branch-discard request.
  always_comb begin
    // A source whose done pulse is showing has just been served this cycle.
    mem_elig = mem_req_i && !mem_done_q;
    if_elig  = if_req_i && !if_done_q;
    if_grant = (state_q == ARB_IDLE) && !mem_elig && if_elig;
    // A branch only counts when ID is actually advancing.
    drop_set = branch_flag_i && (stall_id_i == NO_STOP) &&
               ((state_q == ARB_IF) || if_grant);
  end

  // Next-state logic for the arbiter FSM and its data registers.
  always_comb begin
    state_d     = state_q;
    ram_req_d   = ram_req_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_sel_d   = ram_sel_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    drop_d      = drop_q;
    case (state_q)
      ARB_IDLE: begin
        if (mem_elig) begin
          state_d     = ARB_MEM;
          ram_req_d   = 1'b1;
          ram_we_d    = mem_we_i;
          ram_addr_d  = mem_addr_i;
          ram_wdata_d = mem_wdata_i;
          ram_sel_d   = mem_sel_i;
        end else if (if_elig) begin
          state_d     = ARB_IF;
          ram_req_d   = 1'b1;
          ram_we_d    = 1'b0;
          ram_addr_d  = if_addr_i;
          ram_wdata_d = '0;
          ram_sel_d   = FETCH_SEL;
          if (drop_set) drop_d = 1'b1;
        end
      end
      ARB_IF: begin
        if (ram_ack_i) begin
          state_d   = ARB_IDLE;
          ram_req_d = 1'b0;
          if (drop_q || drop_set) begin
            // Wrong-path fetch: swallow the word silently.
            drop_d = 1'b0;
          end else begin
            if_done_d  = 1'b1;
            if_rdata_d = ram_rdata_i;
          end
        end else if (drop_set) begin
          drop_d = 1'b1;
        end
      end
      ARB_MEM: begin
        if (ram_ack_i) begin
          state_d     = ARB_IDLE;
          ram_req_d   = 1'b0;
          mem_done_d  = 1'b1;
          mem_rdata_d = ram_rdata_i;
        end
      end
      default: begin
        state_d   = ARB_IDLE;
        ram_req_d = 1'b0;
      end
    endcase
  end

  // Arbiter state and output registers; reset abandons any access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_sel_q   <= 4'b0000;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ram_req_q   <= ram_req_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_sel_q   <= ram_sel_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      drop_q      <= drop_d;
    end
  end

  assign ram_req_o   = ram_req_q;
  assign ram_we_o    = ram_we_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_wdata_o = ram_wdata_q;
  assign ram_sel_o   = ram_sel_q;
  assign if_done_o   = if_done_q;
  assign mem_done_o  = mem_done_q;
  assign if_rdata_o  = if_rdata_q;
  assign mem_rdata_o = mem_rdata_q;
  assign state_o     = state_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller for the 5-stage core: owns the shared RAM port
// arbiter and the stall priority encoder feeding the pipeline registers.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              branch_flag,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [3:0]        mem_sel,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [3:0]        ram_sel,
  input  logic              ram_ack,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [5:0]        stall
);

  logic [5:0] stall_c;
  logic [1:0] arb_state;

  // Stall priority encoder; held at all-NoStop while reset is asserted.
  always_comb begin
    stall_c = STALL_NONE;
    if (!rst)                        stall_c = STALL_NONE;
    else if (mem_req && !mem_done)   stall_c = STALL_MEM;
    else if (stallreq_ex)            stall_c = STALL_EX;
    else if (stallreq_id)            stall_c = STALL_ID;
    else if (if_req && !if_done)     stall_c = STALL_IF;
  end

  assign stall = stall_c;

  mem_port_arb #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_arb (
    .clk          (clk),
    .rst_n        (rst),
    .stall_id_i   (stall_c[2]),
    .branch_flag_i(branch_flag),
    .if_req_i     (if_req),
    .if_addr_i    (if_addr),
    .if_rdata_o   (if_rdata),
    .if_done_o    (if_done),
    .mem_req_i    (mem_req),
    .mem_we_i     (mem_we),
    .mem_addr_i   (mem_addr),
    .mem_wdata_i  (mem_wdata),
    .mem_sel_i    (mem_sel),
    .mem_rdata_o  (mem_rdata),
    .mem_done_o   (mem_done),
    .ram_req_o    (ram_req),
    .ram_we_o     (ram_we),
    .ram_addr_o   (ram_addr),
    .ram_wdata_o  (ram_wdata),
    .ram_sel_o    (ram_sel),
    .ram_ack_i    (ram_ack),
    .ram_rdata_i  (ram_rdata),
    .state_o      (arb_state)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: fetch, MEM/IF contention, stall priority,
// branch discard and reset during an access.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic        stallreq_id, stallreq_ex, branch_flag;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_sel;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        ram_req, ram_we;
  logic [31:0] ram_addr, ram_wdata;
  logic [3:0]  ram_sel;
  logic        ram_ack;
  logic [31:0] ram_rdata;
  logic [5:0]  stall;

  int checks;
  int errors;

  // Clock and DUT.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipe_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex), .branch_flag(branch_flag),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_sel(mem_sel), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_sel(ram_sel), .ram_ack(ram_ack), .ram_rdata(ram_rdata), .stall(stall)
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b0;
    stallreq_id = 0; stallreq_ex = 0; branch_flag = 0;
    if_req = 0; if_addr = '0;
    mem_req = 0; mem_we = 0; mem_addr = '0; mem_wdata = '0; mem_sel = '0;
    ram_ack = 0; ram_rdata = '0;

    // Reset state.
    tick();
    check("rst_ram_req", ram_req, 0);
    check("rst_stall", stall, 6'b000000);
    check("rst_if_done", if_done, 0);
    check("rst_mem_done", mem_done, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_state", dut.u_arb.state_o, ARB_IDLE);
    rst = 1'b1;
    tick();

    // Simple fetch at 0x100.
    if_req = 1; if_addr = 32'h100;
    #1 check("f1_stall_req", stall, 6'b000011);
    tick();
    check("f1_ram_req", ram_req, 1);
    check("f1_ram_addr", ram_addr, 32'h100);
    check("f1_ram_we", ram_we, 0);
    check("f1_ram_sel", ram_sel, 4'b1111);
    tick();
    check("f1_req_held", ram_req, 1);
    check("f1_stall_wait", stall, 6'b000011);
    ram_ack = 1; ram_rdata = 32'hDEADBEEF;
    tick();
    ram_ack = 0;
    check("f1_done", if_done, 1);
    check("f1_rdata", if_rdata, 32'hDEADBEEF);
    check("f1_req_drop", ram_req, 0);
    check("f1_stall_done", stall, 6'b000000);
    if_req = 0;
    tick();
    check("f1_done_pulse", if_done, 0);
    check("f1_rdata_hold", if_rdata, 32'hDEADBEEF);

    // Simultaneous IF and MEM store: MEM first.
    if_req = 1; if_addr = 32'h104;
    mem_req = 1; mem_we = 1; mem_addr = 32'h200; mem_wdata = 32'h12345678; mem_sel = 4'b1111;
    #1 check("c_stall_mem", stall, 6'b011111);
    tick();
    check("c_mem_we", ram_we, 1);
    check("c_mem_addr", ram_addr, 32'h200);
    check("c_mem_wdata", ram_wdata, 32'h12345678);
    check("c_mem_sel", ram_sel, 4'b1111);
    check("c_state_mem", dut.u_arb.state_o, ARB_MEM);
    check("c_stall_mem2", stall, 6'b011111);
    ram_ack = 1; ram_rdata = 32'h0;
    tick();
    ram_ack = 0;
    check("c_mem_done", mem_done, 1);
    check("c_if_done0", if_done, 0);
    check("c_stall_if", stall, 6'b000011);
    mem_req = 0; mem_we = 0;
    tick();
    check("c_if_grant", ram_req, 1);
    check("c_if_addr", ram_addr, 32'h104);
    check("c_if_we", ram_we, 0);
    check("c_mem_done_pulse", mem_done, 0);
    ram_ack = 1; ram_rdata = 32'hCAFEF00D;
    tick();
    ram_ack = 0;
    check("c_if_done", if_done, 1);
    check("c_if_rdata", if_rdata, 32'hCAFEF00D);
    if_req = 0;
    tick();

    // EX stall for exactly three cycles.
    stallreq_ex = 1;
    #1 check("ex_c1", stall, 6'b001111);
    tick();
    check("ex_c2", stall, 6'b001111);
    tick();
    check("ex_c3", stall, 6'b001111);
    check("ex_no_ram", ram_req, 0);
    tick();
    stallreq_ex = 0;
    #1 check("ex_end", stall, 6'b000000);

    // ID stall over a pending fetch.
    tick();
    stallreq_id = 1; if_req = 1; if_addr = 32'h108;
    #1 check("id_stall", stall, 6'b000111);
    tick();
    check("id_stall_acc", stall, 6'b000111);
    check("id_ram_addr", ram_addr, 32'h108);
    stallreq_id = 0;
    ram_ack = 1; ram_rdata = 32'h00000011;
    tick();
    ram_ack = 0;
    check("id_done", if_done, 1);
    check("id_rdata", if_rdata, 32'h00000011);
    if_req = 0;
    tick();

    // Branch discards the in-flight fetch.
    if_req = 1; if_addr = 32'h10C;
    tick();
    check("br_req", ram_req, 1);
    check("br_stall", stall, 6'b000011);
    branch_flag = 1;
    tick();
    branch_flag = 0;
    ram_ack = 1; ram_rdata = 32'hBAD0BAD0;
    tick();
    ram_ack = 0;
    check("br_no_done", if_done, 0);
    check("br_rdata_kept", if_rdata, 32'h00000011);
    check("br_req_drop", ram_req, 0);
    if_addr = 32'h300;
    tick();
    check("br_new_req", ram_req, 1);
    check("br_new_addr", ram_addr, 32'h300);
    ram_ack = 1; ram_rdata = 32'h600D600D;
    tick();
    ram_ack = 0;
    check("br_new_done", if_done, 1);
    check("br_new_rdata", if_rdata, 32'h600D600D);
    if_req = 0;
    tick();

    // Reset while MEM access waits for ack.
    mem_req = 1; mem_we = 0; mem_addr = 32'h400; mem_sel = 4'b0011;
    tick();
    check("rm_req", ram_req, 1);
    check("rm_sel", ram_sel, 4'b0011);
    #3 rst = 1'b0;
    #1 check("rm_req_async", ram_req, 0);
    check("rm_stall_async", stall, 6'b000000);
    tick();
    rst = 1'b1; mem_req = 0;
    check("rm_state_idle", dut.u_arb.state_o, ARB_IDLE);
    ram_ack = 1; ram_rdata = 32'h55555555;
    tick();
    ram_ack = 0;
    check("rm_late_ack_done", mem_done, 0);
    check("rm_late_ack_rdata", mem_rdata, 32'h0);
    check("rm_late_ack_req", ram_req, 0);
    tick();
    check("rm_after", mem_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline controller for the 5-stage core.
- Arbitrates the single shared RAM port between instruction fetch (IF) and the MEM stage.
- Sequences each RAM access with a req/ack handshake.
- Produces the stall[5:0] vector consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb.
- A stall vector of stall[k]=Stop with stall[k+1]=NoStop makes the downstream pipeline register insert a bubble.

Parameters:
ADDR_W, 32, RAM address width
DATA_W, 32, RAM data width

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-low reset
stallreq_id  in  1  load-use stall request from ID
stallreq_ex  in  1  multi-cycle ALU stall request from EX
branch_flag  in  1  taken branch/jump resolved in ID this cycle
if_req  in  1  IF fetch request
if_addr  in  ADDR_W  fetch address
if_rdata  out  DATA_W  fetched word, valid while if_done
if_done  out  1  one-cycle fetch completion pulse
mem_req  in  1  MEM-stage access request
mem_we  in  1  1 = store
mem_addr  in  ADDR_W  data address
mem_wdata  in  DATA_W  store data
mem_sel  in  4  byte enables
mem_rdata  out  DATA_W  load data, valid while mem_done
mem_done  out  1  one-cycle access completion pulse
ram_req  out  1  RAM request, held until ack
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_sel  out  4  RAM byte enables
ram_ack  in  1  RAM completion; ram_rdata valid this cycle
ram_rdata  in  DATA_W  RAM read data
stall  out  6  stall vector, bit0 pc .. bit5 wb; 1 = Stop

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; ram_req/ram_we/ram_sel/ram_addr/ram_wdata=0; if_done/mem_done=0; if_rdata/mem_rdata=0; drop=0; stall=000000.
  - Reset mid-access drops ram_req immediately; the access is abandoned and no done pulse is issued.
- FSM states: IDLE, IF_ACC, MEM_ACC. All ram_* outputs are registered.
- Arbitration in IDLE, evaluated each cycle:
  - A source whose done pulse is high in this cycle is not eligible.
  - Among eligible sources, MEM has priority over IF, because MEM holds the older instruction.
  - On grant, register the ram_* fields from the granted source, set ram_req=1, and move to IF_ACC or MEM_ACC.
- IF_ACC / MEM_ACC:
  - ram_req and all ram_* fields stay stable until ram_ack.
  - On ram_ack in cycle N: cycle N+1 has ram_req=0, state=IDLE, the matching done=1 for exactly one cycle, and the matching rdata=ram_rdata captured at N.
  - rdata holds its value after done falls.
  - Minimum access is 2 cycles: grant at N-1, ack at N.
  - Ack arriving in the grant cycle is a RAM protocol violation; it is ignored.
- Branch discard:
  - If branch_flag=1, stall[2]=NoStop and state=IF_ACC (or an IF grant is happening this cycle), set drop=1.
  - On the corresponding ack, if_done stays 0, if_rdata is unchanged, and drop is cleared.
  - IF then re-requests with the new PC.
  - branch_flag is ignored while stall[2]=Stop.
- Stall vector (combinational from registered state and inputs), highest priority first:
  - mem_req && !mem_done → 011111
  - stallreq_ex → 001111
  - stallreq_id → 000111
  - if_req && !if_done → 000011 (ID receives a bubble)
  - otherwise → 000000
- Simultaneous requests: MEM is granted; IF keeps requesting and stall follows the MEM row; IF is granted in the first eligible IDLE cycle after mem_done.
- Single outstanding RAM access at all times; no pipelining of requests.

Decomposition:
- defines.v gains:
  - Stop/NoStop (existing)
  - Arbiter state encodings ArbIdle, ArbIf, ArbMem
  - Stall vector constants StallMem, StallEx, StallId, StallIf, StallNone
- One sub-module, mem_port_arb: FSM, ram_* registers, drop flag, rdata/done registers.
- pipe_ctrl instantiates mem_port_arb and contains the stall priority encoder.

Test Plan:
- Reset then IF request at 0x100, ack 2 cycles after grant with rdata 0xDEADBEEF → ram_addr=0x100; stall=000011 until if_done; if_done one cycle with if_rdata=0xDEADBEEF; stall=000000.
- if_req and mem_req (store, addr 0x200, wdata 0x12345678, sel 1111) raised the same cycle → MEM granted first with ram_we=1; stall=011111; after mem_done, IF granted next IDLE cycle.
- stallreq_ex=1 for 3 cycles with no RAM activity → stall=001111 for exactly those 3 cycles.
- stallreq_id=1 together with a pending fetch → stall=000111.
- Fetch in flight, branch_flag=1 with stall[2]=0 → on ack, if_done stays 0; next IF request at the new PC completes normally.
- rst asserted while MEM_ACC is waiting for ack → ram_req=0 and stall=000000 immediately; after release state=IDLE and a late ram_ack produces no done pulse.
